// File: rtl/st_packet_arbiter.sv
// Two-input packet-aware round-robin arbiter: merges two valid/ready packet
// streams into one registered output, never interleaving beats of different packets.
module st_packet_arbiter #(
  parameter int DWIDTH = 512,
  parameter int EWIDTH = 6,
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DWIDTH-1:0] in0_data,
  input  logic              in0_sop,
  input  logic              in0_eop,
  input  logic [EWIDTH-1:0] in0_empty,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DWIDTH-1:0] in1_data,
  input  logic              in1_sop,
  input  logic              in1_eop,
  input  logic [EWIDTH-1:0] in1_empty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [EWIDTH-1:0] out_empty,
  output logic              out_channel,
  output logic [CWIDTH-1:0] pkt_cnt0,
  output logic [CWIDTH-1:0] pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_vld_p0;
  logic [DWIDTH-1:0] r_data_p0;
  logic              r_sop_p0;
  logic              r_eop_p0;
  logic [EWIDTH-1:0] r_empty_p0;
  logic              r_chan_p0;
  logic [CWIDTH-1:0] r_cnt0;
  logic [CWIDTH-1:0] r_cnt1;

  logic              w_adv;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_load;
  logic              w_sel;
  logic [DWIDTH-1:0] w_data;
  logic              w_sop;
  logic              w_eop;
  logic [EWIDTH-1:0] w_empty;

  assign w_adv = ~r_vld_p0 | out_ready;

  // In IDLE a tie goes to the channel that did not finish the previous packet.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      IDLE: begin
        if (in0_valid && (!in1_valid || r_last_grant)) begin
          w_gnt0 = 1'b1;
        end else if (in1_valid) begin
          w_gnt1 = 1'b1;
        end
      end
      LOCK0:   w_gnt0 = 1'b1;
      LOCK1:   w_gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign in0_ready = w_gnt0 & w_adv;
  assign in1_ready = w_gnt1 & w_adv;
  assign w_acc0    = in0_valid & in0_ready;
  assign w_acc1    = in1_valid & in1_ready;
  assign w_load    = w_acc0 | w_acc1;
  assign w_sel     = w_acc1;

  assign w_data  = w_sel ? in1_data  : in0_data;
  assign w_sop   = w_sel ? in1_sop   : in0_sop;
  assign w_eop   = w_sel ? in1_eop   : in0_eop;
  assign w_empty = w_sel ? in1_empty : in0_empty;

  // Stage p0: output register, grant FSM and per-channel EOP counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_vld_p0     <= 1'b0;
      r_data_p0    <= '0;
      r_sop_p0     <= 1'b0;
      r_eop_p0     <= 1'b0;
      r_empty_p0   <= '0;
      r_chan_p0    <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      if (w_load) begin
        r_vld_p0   <= 1'b1;
        r_data_p0  <= w_data;
        r_sop_p0   <= w_sop;
        r_eop_p0   <= w_eop;
        r_empty_p0 <= w_empty;
        r_chan_p0  <= w_sel;
        if (w_eop) begin
          r_state      <= IDLE;
          r_last_grant <= w_sel;
          if (w_sel) begin
            r_cnt1 <= r_cnt1 + CWIDTH'(1);
          end else begin
            r_cnt0 <= r_cnt0 + CWIDTH'(1);
          end
        end else begin
          r_state <= w_sel ? LOCK1 : LOCK0;
        end
      end else if (out_ready) begin
        r_vld_p0 <= 1'b0;
      end
    end
  end

  assign out_valid   = r_vld_p0;
  assign out_data    = r_data_p0;
  assign out_sop     = r_sop_p0;
  assign out_eop     = r_eop_p0;
  assign out_empty   = r_empty_p0;
  assign out_channel = r_chan_p0;
  assign pkt_cnt0    = r_cnt0;
  assign pkt_cnt1    = r_cnt1;

endmodule

// File: doc/st_packet_arbiter.md
# st_packet_arbiter

Two-input, packet-aware round-robin arbiter that shares one streaming output between two packet sources. It uses the same valid/ready/data convention as the two-input streaming multiplexer, but it never interleaves beats of different packets. A grant is held from the SOP beat through the EOP beat. It sits ahead of the packet buffer / parser stage, merging the two ingress streams, and drives a registered output stage with a channel tag and per-channel packet counters.

## Interface
Parameters:
- DWIDTH, 512, data beat width in bits.
- EWIDTH, 6, width of the empty (invalid-byte count) field; valid only on EOP beats.
- CWIDTH, 32, width of per-channel packet counters.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- in0_valid  in  1  channel 0 beat valid.
- in0_ready  out  1  channel 0 beat accepted when in0_valid & in0_ready.
- in0_data  in  DWIDTH  channel 0 beat data.
- in0_sop  in  1  channel 0 first beat of packet.
- in0_eop  in  1  channel 0 last beat of packet.
- in0_empty  in  EWIDTH  channel 0 empty count.
- in1_valid, in1_ready, in1_data, in1_sop, in1_eop, in1_empty: same widths and meanings, channel 1.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_data  out  DWIDTH  registered beat data.
- out_sop, out_eop  out  1  registered framing.
- out_empty  out  EWIDTH  registered empty count.
- out_channel  out  1  source of the current output beat (0/1).
- pkt_cnt0, pkt_cnt1  out  CWIDTH  EOP beats forwarded per channel.

## Operation
- FSM states:
  - IDLE: no packet owns the output.
  - LOCK0: channel 0 mid-packet.
  - LOCK1: channel 1 mid-packet.
- Output register enable: adv = ~out_valid | out_ready. A beat moves into the register only when adv = 1.
- Grant in IDLE (combinational):
  - Only one inX_valid high: grant that channel.
  - Both valid: grant the channel != last_grant.
  - Neither valid: no grant.
- Grant in LOCKx: channel x only. The other channel's ready is 0.
- inX_ready = granted_x & adv. The ungranted channel's ready is always 0.
- On accepted beat from channel x:
  - Load out_* with that beat and set out_channel = x.
  - Beat is not EOP: next state LOCKx.
  - Beat is EOP: next state IDLE, last_grant <= x, pkt_cnt_x increments.
  - A single-beat packet (sop & eop) stays in IDLE.
- out_valid clears when out_ready = 1 and no new beat is loaded that cycle.
- Framing is trusted, not checked:
  - The arbiter switches only on EOP.
  - An SOP seen while in LOCKx is forwarded as ordinary data.
- pkt_cnt wraps modulo 2^CWIDTH without saturation.
- Reset (also mid-packet) forces:
  - state IDLE, last_grant = 1 (channel 0 wins the first tie), out_valid = 0.
  - out_data/out_sop/out_eop/out_empty/out_channel = 0, pkt_cnt0 = pkt_cnt1 = 0.
  - Any partially forwarded packet is abandoned, with no EOP emitted.

## Timing
- Latency: input accept to out_valid is 1 cycle (registered output).
- Throughput: 1 beat/cycle sustained while out_ready = 1, including across packet boundaries.
- Packet switch costs zero bubbles: an EOP accepted in cycle N from channel 0 allows channel 1's SOP to be accepted in cycle N+1.
- Backpressure:
  - out_ready = 0 with out_valid = 1 drops both inX_ready in the same cycle (combinational path out_ready to inX_ready).
  - Data is held stable and no beat is lost or duplicated.
- inX_ready may toggle only with out_ready, grant, or state. It never depends on the opposing channel while locked.
- Counters update on the cycle the EOP beat is accepted from the input, not when it leaves the output.

## Test plan
- Reset, then both idle: out_valid = 0, pkt_cnt0 = pkt_cnt1 = 0, in0_ready = in1_ready = 0.
- Channel 0 sends a 4-beat packet (data 0xA0..0xA3) while channel 1 is held valid from cycle 1:
  - Output is 0xA0..0xA3 with channel 0 on cycles 1–4.
  - Channel 1's SOP is accepted in the cycle right after 0xA3 is accepted.
  - in1_ready = 0 throughout the lock.
- Both channels are continuously valid with single-beat packets:
  - Output channel sequence is 0,1,0,1,…
  - After 10 packets, pkt_cnt0 = 5 and pkt_cnt1 = 5.
- out_ready toggles 1,0,0,1 during a 3-beat packet: every beat appears exactly once and in order, and out_data is held stable while stalled.
- reset_n is pulsed low in cycle 2 of a 5-beat channel 1 packet:
  - Next cycle shows out_valid = 0, state IDLE, counters 0.
  - A subsequent tie grants channel 0.
- Preload pkt_cnt0 to 2^CWIDTH−1 (CWIDTH override 4, i.e. 15 packets), then send one more packet: pkt_cnt0 wraps to 0.
